// File: rtl/decimal_entry_controller_pkg.sv
// Shared digit-state codes and limits for the decimal entry and display paths.
// No timing of its own; constants and types only.
package decimal_entry_controller_pkg;

    localparam logic [1:0] DIG_HUNDREDS = 2'd0;
    localparam logic [1:0] DIG_TENS     = 2'd1;
    localparam logic [1:0] DIG_ONES     = 2'd2;
    localparam logic [1:0] DIG_DONE     = 2'd3;

    localparam logic [3:0] DISPLAY_OFF  = 4'd10;
    localparam logic [7:0] VALUE_MAX    = 8'd255;

    typedef enum logic [1:0] {
        ENTER_H = DIG_HUNDREDS,
        ENTER_T = DIG_TENS,
        ENTER_O = DIG_ONES,
        DONE    = DIG_DONE
    } entry_state_t;

endpackage

// File: rtl/decimal_entry_controller_button_edge_detector.sv
// Synchronizes a raw button level and emits a one-cycle pulse on its rising edge.
// Pulse is high SYNC_STAGES cycles after the first sampled high; no backpressure.
module button_edge_detector #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/decimal_entry_controller.sv
// Two-button decimal entry (hundreds, tens, ones) assembled into a saturated 8-bit value.
// Button to output effect is SYNC_STAGES+1 cycles; no backpressure, value_valid is a bare pulse.
module decimal_entry_controller
    import decimal_entry_controller_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_inc,
    input  logic       btn_next,
    output logic [1:0] digit_sel,
    output logic [3:0] cur_digit,
    output logic [7:0] value,
    output logic       value_valid,
    output logic       overflow
);

    entry_state_t state;
    logic [3:0]   h, t, o;
    logic         inc_p, next_p;
    logic [8:0]   h9, t9, o9, sum;

    button_edge_detector #(.SYNC_STAGES(SYNC_STAGES)) u_inc_edge (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_inc),
        .pulse (inc_p)
    );

    button_edge_detector #(.SYNC_STAGES(SYNC_STAGES)) u_next_edge (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_next),
        .pulse (next_p)
    );

    // h*100 + t*10 + o by shift-add; worst case 299 fits in 9 bits
    assign h9  = {5'd0, h};
    assign t9  = {5'd0, t};
    assign o9  = {5'd0, o};
    assign sum = (h9 << 6) + (h9 << 5) + (h9 << 2) + (t9 << 3) + (t9 << 1) + o9;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ENTER_H;
            h           <= 4'd0;
            t           <= 4'd0;
            o           <= 4'd0;
            value       <= 8'd0;
            value_valid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            // next_p takes priority so a simultaneous inc_p is dropped
            case (state)
                ENTER_H: begin
                    if (next_p)     state <= ENTER_T;
                    else if (inc_p) h <= (h == 4'd2) ? 4'd0 : h + 4'd1;
                end
                ENTER_T: begin
                    if (next_p)     state <= ENTER_O;
                    else if (inc_p) t <= (t == 4'd9) ? 4'd0 : t + 4'd1;
                end
                ENTER_O: begin
                    if (next_p) begin
                        state       <= DONE;
                        value_valid <= 1'b1;
                        if (sum > {1'b0, VALUE_MAX}) begin
                            value    <= VALUE_MAX;
                            overflow <= 1'b1;
                        end else begin
                            value    <= sum[7:0];
                            overflow <= 1'b0;
                        end
                    end else if (inc_p) begin
                        o <= (o == 4'd9) ? 4'd0 : o + 4'd1;
                    end
                end
                DONE: begin
                    if (next_p) begin
                        state <= ENTER_H;
                        h     <= 4'd0;
                        t     <= 4'd0;
                        o     <= 4'd0;
                    end
                end
                default: state <= ENTER_H;
            endcase
        end
    end

    always_comb begin
        cur_digit = DISPLAY_OFF;
        case (state)
            ENTER_H: cur_digit = h;
            ENTER_T: cur_digit = t;
            ENTER_O: cur_digit = o;
            default: cur_digit = DISPLAY_OFF;
        endcase
    end

    assign digit_sel = state;

endmodule

// File: tb/tb_decimal_entry_controller.sv
// Directed bench for decimal_entry_controller with hand-computed expectations.
module tb_decimal_entry_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_inc = 1'b0;
    logic       btn_next = 1'b0;
    logic [1:0] digit_sel;
    logic [3:0] cur_digit;
    logic [7:0] value;
    logic       value_valid;
    logic       overflow;

    int n_vec = 0;
    int n_bad = 0;
    int vv_cnt = 0;
    int vv_base;

    decimal_entry_controller #(.SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_inc     (btn_inc),
        .btn_next    (btn_next),
        .digit_sel   (digit_sel),
        .cur_digit   (cur_digit),
        .value       (value),
        .value_valid (value_valid),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (value_valid) vv_cnt++;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_inc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) btn_inc = 1'b1;
            idle(3);
            btn_inc = 1'b0;
            idle(4);
        end
    endtask

    task automatic press_next();
        @(negedge clk) btn_next = 1'b1;
        idle(3);
        btn_next = 1'b0;
        idle(4);
    endtask

    task automatic enter(input int hh, input int tt, input int oo);
        press_inc(hh); press_next();
        press_inc(tt); press_next();
        press_inc(oo); press_next();
    endtask

    initial begin
        idle(3);
        @(negedge clk) rst = 1'b0;
        idle(20);
        check("rst_sel",   digit_sel,   0);
        check("rst_cur",   cur_digit,   0);
        check("rst_value", value,       0);
        check("rst_vv",    value_valid, 0);
        check("rst_ovf",   overflow,    0);

        // 1,2,8 -> 128, watching each step
        press_inc(1);  check("e128_h",    cur_digit, 1);
        press_next();  check("e128_sel1", digit_sel, 1);
        press_inc(2);  check("e128_t",    cur_digit, 2);
        press_next();  check("e128_sel2", digit_sel, 2);
        press_inc(8);  check("e128_o",    cur_digit, 8);
        vv_base = vv_cnt;
        press_next();
        check("e128_sel3",  digit_sel, 3);
        check("e128_value", value,     128);
        check("e128_ovf",   overflow,  0);
        check("e128_cur",   cur_digit, 10);
        check("e128_vv",    vv_cnt - vv_base, 1);

        press_next();
        check("restart_sel", digit_sel, 0);
        check("restart_cur", cur_digit, 0);

        // 2,9,9 = 299 saturates
        enter(2, 9, 9);
        check("e299_value", value,    255);
        check("e299_ovf",   overflow, 1);
        press_next();
        press_next(); press_next(); press_inc(7);
        check("hold_value", value,     255);
        check("hold_ovf",   overflow,  1);
        check("e007_cur",   cur_digit, 7);
        vv_base = vv_cnt;
        press_next();
        check("e007_value", value,    7);
        check("e007_ovf",   overflow, 0);
        check("e007_vv",    vv_cnt - vv_base, 1);

        // wrap-around and held button
        press_next();
        press_inc(3);  check("wrap_h", cur_digit, 0);
        press_next();
        press_inc(10); check("wrap_t", cur_digit, 0);
        @(negedge clk) btn_inc = 1'b1;
        idle(50);
        btn_inc = 1'b0;
        idle(4);
        check("held_inc", cur_digit, 1);
        press_inc(3);  check("t_is_4", cur_digit, 4);

        // simultaneous edges in ENTER_T: next wins, t stays 4
        @(negedge clk) begin btn_inc = 1'b1; btn_next = 1'b1; end
        idle(3);
        btn_inc = 1'b0; btn_next = 1'b0;
        idle(4);
        check("simul_sel", digit_sel, 2);
        check("simul_o",   cur_digit, 0);
        press_next();
        check("simul_value", value, 40);

        // inc ignored in DONE
        vv_base = vv_cnt;
        press_inc(2);
        check("done_sel",   digit_sel, 3);
        check("done_cur",   cur_digit, 10);
        check("done_value", value,     40);
        check("done_vv",    vv_cnt - vv_base, 0);

        // async reset mid-entry
        press_next();
        enter(1, 2, 8);
        check("pre_rst_value", value, 128);
        press_next();
        press_inc(1); press_next(); press_next(); press_inc(3);
        check("pre_rst_sel", digit_sel, 2);
        check("pre_rst_cur", cur_digit, 3);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_sel",   digit_sel,   0);
        check("arst_cur",   cur_digit,   0);
        check("arst_value", value,       0);
        check("arst_vv",    value_valid, 0);
        check("arst_ovf",   overflow,    0);
        @(negedge clk) rst = 1'b0;
        idle(4);

        // 2,5,5 = 255 is the largest non-overflowing value
        vv_base = vv_cnt;
        enter(2, 5, 5);
        check("e255_value", value,     255);
        check("e255_ovf",   overflow,  0);
        check("e255_sel",   digit_sel, 3);
        check("e255_vv",    vv_cnt - vv_base, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
